// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, command record.
// Optional divide-by-zero trapping is enabled with ALU_SEQ_DIVZERO_ERR_EN.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        MOD  = 3'b010,
        MUL  = 3'b011,
        LAND = 3'b100,
        LOR  = 3'b101,
        LNOT = 3'b110,
        EQ   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    function automatic logic is_divzero(cmd_t c);
        return (c.opcode == MOD) && (c.b == 4'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU-side and result handshake signals.
// Master drives commands and the ALU result; slave is the sequencer.
interface alu_cmd_sequencer_if;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic       alu_en;
    logic [7:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;

    modport master (
        output in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_opcode, alu_en,
        input  out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_opcode, alu_en,
        output out_valid, out_data, out_err
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Command FIFO for the ALU sequencer; pointers wrap naturally (DEPTH is 2^n).
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  cmd_t          wdata_i,
    output cmd_t          rdata_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time, registers results downstream.
// Define ALU_SEQ_DIVZERO_ERR_EN to trap MOD by zero as an 8'hFF error result.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    alu_cmd_sequencer_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    cmd_t          head;
    cmd_t          wcmd;
    logic          push, pop, empty, alu_en;
    logic [CW-1:0] fifo_cnt;
    logic [3:0]    a_q, b_q;
    opcode_e       op_q;
    logic [7:0]    data_q;
    logic          valid_q;

    assign bus.in_ready = (fifo_cnt != CW'(DEPTH));
    assign push = bus.in_valid & bus.in_ready;
    assign wcmd = '{opcode: opcode_e'(bus.in_opcode),
                    a: bus.in_a, b: bus.in_b};

    alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wcmd),
        .rdata_o (head),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );

`ifdef ALU_SEQ_DIVZERO_ERR_EN
    logic divz_q, err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            divz_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (pop) divz_q <= is_divzero(head);
            if (state_q == ISSUE) err_q <= divz_q;
        end
    end

    assign bus.out_err = err_q;
`else
    logic divz_q;
    assign divz_q      = 1'b0;
    assign bus.out_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        alu_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                alu_en  = ~divz_q;
                state_d = RESP;
            end
            RESP: begin
                if (bus.out_ready) begin
                    pop     = ~empty;
                    state_d = empty ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ADD;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                a_q  <= head.a;
                b_q  <= head.b;
                op_q <= head.opcode;
            end
            if (state_q == ISSUE) begin
                valid_q <= 1'b1;
                data_q  <= divz_q ? 8'hFF : bus.alu_result;
            end else if (state_q == RESP && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_en     = alu_en;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed table, corner sequences, random scoreboard.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] d;
        logic       e;
        int         en;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   en_cnt = 0;
    int   dlv_cnt = 0;
    logic [8:0] exp_q[$];
    vec_t tbl[10];

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        logic [7:0] xa, xb;
        xa = {4'b0, a};
        xb = {4'b0, b};
        case (op)
            3'd0: return xa + xb;
            3'd1: return xa - xb;
            3'd2: return (b == 0) ? 8'h00 : xa % xb;
            3'd3: return xa * xb;
            3'd4: return {7'b0, (a != 0) && (b != 0)};
            3'd5: return {7'b0, (a != 0) || (b != 0)};
            3'd6: return {7'b0, a == 0};
            default: return {7'b0, a == b};
        endcase
    endfunction

    function automatic logic [8:0] ref_res(logic [2:0] op, logic [3:0] a, logic [3:0] b);
`ifdef ALU_SEQ_DIVZERO_ERR_EN
        if (op == 3'd2 && b == 0) return {1'b1, 8'hFF};
`endif
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    // External combinational ALU; garbage when disabled so stray captures show.
    always_comb bus.alu_result = bus.alu_en ?
        alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b) : 8'hA5;

    always @(negedge clk) if (bus.alu_en) en_cnt++;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_alu_a"}, bus.alu_a, 0);
        chk({tag, "_alu_b"}, bus.alu_b, 0);
        chk({tag, "_alu_op"}, bus.alu_opcode, 0);
        chk({tag, "_alu_en"}, bus.alu_en, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_err"}, bus.out_err, 0);
    endtask

    task automatic step();
        logic       hold;
        logic [8:0] pd;
        logic [8:0] e;
        hold = bus.out_valid && !bus.out_ready;
        pd   = {bus.out_err, bus.out_data};
        if (bus.out_valid && bus.out_ready) begin
            dlv_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_result", {bus.out_err, bus.out_data}, 9'h1ZZ);
            end else begin
                e = exp_q.pop_front();
                chk("result", {bus.out_err, bus.out_data}, e);
            end
        end
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_res(bus.in_opcode, bus.in_a, bus.in_b));
        @(posedge clk); #1;
        if (hold) chk("held_result", {bus.out_valid, bus.out_err, bus.out_data}, {1'b1, pd});
    endtask

    task automatic run_single(vec_t v);
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = v.op;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        chk("single_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        en_cnt = 0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 2);
        chk("single_data", bus.out_data, v.d);
        chk("single_err", bus.out_err, v.e);
        @(posedge clk); #1;
        chk("valid_cleared", bus.out_valid, 0);
        chk("alu_en_cycles", en_cnt, v.en);
    endtask

    initial begin
        int k;
        int vcnt;
        tbl[0] = '{3'd0, 4'd3, 4'd5, 8'h08, 1'b0, 1};
        tbl[1] = '{3'd3, 4'd15, 4'd15, 8'hE1, 1'b0, 1};
        tbl[2] = '{3'd1, 4'd2, 4'd5, 8'hFD, 1'b0, 1};
        tbl[3] = '{3'd2, 4'd7, 4'd3, 8'h01, 1'b0, 1};
`ifdef ALU_SEQ_DIVZERO_ERR_EN
        tbl[4] = '{3'd2, 4'd7, 4'd0, 8'hFF, 1'b1, 0};
`else
        tbl[4] = '{3'd2, 4'd7, 4'd0, 8'h00, 1'b0, 1};
`endif
        tbl[5] = '{3'd7, 4'd4, 4'd4, 8'h01, 1'b0, 1};
        tbl[6] = '{3'd4, 4'd3, 4'd0, 8'h00, 1'b0, 1};
        tbl[7] = '{3'd5, 4'd0, 4'd9, 8'h01, 1'b0, 1};
        tbl[8] = '{3'd6, 4'd0, 4'd6, 8'h01, 1'b0, 1};
        tbl[9] = '{3'd7, 4'd4, 4'd5, 8'h00, 1'b0, 1};

        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("reset");

        foreach (tbl[i]) run_single(tbl[i]);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom % 3) != 0;
            bus.in_opcode = 3'($urandom_range(0, 7));
            bus.in_a      = 4'($urandom_range(0, 15));
            bus.in_b      = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom % 3) != 0;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) step();
        chk("random_drain", exp_q.size(), 0);

        // Backpressure: fill FIFO plus the RESP slot.
        dlv_cnt = 0;
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 2 * DEPTH + 4; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_opcode = 3'd0;
            bus.in_a      = k[3:0];
            bus.in_b      = 4'd1;
            if (bus.in_ready) k++;
            step();
        end
        chk("bp_accepted", k, DEPTH + 1);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_queue_len", exp_q.size(), DEPTH + 1);
        chk("bp_first_held", {bus.out_valid, bus.out_data},
            {1'b1, (exp_q.size() > 0) ? exp_q[0][7:0] : 8'h00});

        // Full FIFO with a pop and an offered push on the same edge.
        bus.out_ready = 1'b1;
        chk("full_push_refused", bus.in_ready, 0);
        step();
        chk("count_dec_ready", bus.in_ready, 1);
        for (int c = 0; c < 40; c++) begin
            if (k == DEPTH + 2 && exp_q.size() == 0) break;
            bus.in_valid = (k < DEPTH + 2);
            bus.in_a     = k[3:0];
            if (bus.in_valid && bus.in_ready) k++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_delivered", dlv_cnt, DEPTH + 2);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset while in RESP with commands queued.
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_opcode = 3'd0;
            bus.in_a      = k[3:0];
            bus.in_b      = 4'd2;
            if (bus.in_ready) k++;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk_reset("midrst");
        bus.out_ready = 1'b1;
        vcnt = 0;
        repeat (10) begin
            if (bus.out_valid) vcnt++;
            @(posedge clk); #1;
        end
        chk("no_stale_result", vcnt, 0);
        run_single(tbl[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
